// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Number of pipeline stages; a zero chunk is trapped by the top-level check.
  function automatic int unsigned stages(input int unsigned width, input int unsigned chunk);
    return (chunk == 0) ? 1 : width / chunk;
  endfunction

  // One-bit full adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple-carry slice built from full-adder cells.
module adder_chunk
  import adder_pkg::*;
#(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] w_c;

  // Ripple the carry through the slice bit by bit.
  always_comb begin
    w_c    = '0;
    s      = '0;
    w_c[0] = ci;
    for (int i = 0; i < int'(CHUNK); i++) begin
      {w_c[i+1], s[i]} = full_add(a[i], b[i], w_c[i]);
    end
  end

  assign co       = w_c[CHUNK];
  assign c_msb_in = w_c[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract unit whose carry chain is cut into CHUNK-bit pipeline stages.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = stages(WIDTH, CHUNK);

  if (CHUNK < 1) begin : g_bad_chunk
    $error("pipelined_adder: CHUNK must be at least 1");
  end else if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
  end

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;

  // Per-stage combinational values: stage inputs, slice results and next register value.
  logic [WIDTH-1:0] w_x_in  [STAGES];
  logic [WIDTH-1:0] w_y_in  [STAGES];
  logic [WIDTH-1:0] w_x_nxt [STAGES];
  logic             w_c_in  [STAGES];
  logic             w_v_in  [STAGES];
  logic [CHUNK-1:0] w_s     [STAGES];
  logic             w_co    [STAGES];
  logic             w_cm    [STAGES];

  // Stage registers: r_x mixes resolved sum chunks (low) with skewed A chunks (high),
  // r_y carries the still-unused B' chunks.
  logic [WIDTH-1:0] r_x [STAGES];
  logic [WIDTH-1:0] r_y [STAGES];
  logic             r_c [STAGES];
  logic             r_o [STAGES];
  logic             r_v [STAGES];

  // Global advance: the whole pipe moves unless the output is held by downstream.
  assign w_adv    = !r_v[STAGES-1] || out_ready;
  assign in_ready = w_adv;

  // Operand conditioning: subtraction is a + ~b + 1, carry-in ignored.
  always_comb begin
    w_b_eff   = b;
    w_cin_eff = cin;
    case (sub)
      OP_ADD: begin
        w_b_eff   = b;
        w_cin_eff = cin;
      end
      OP_SUB: begin
        w_b_eff   = ~b;
        w_cin_eff = 1'b1;
      end
      default: ;
    endcase
  end

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    localparam logic [WIDTH-1:0] L_MASK = WIDTH'({CHUNK{1'b1}}) << (k * CHUNK);

    if (k == 0) begin : g_first
      assign w_x_in[k] = a;
      assign w_y_in[k] = w_b_eff;
      assign w_c_in[k] = w_cin_eff;
      assign w_v_in[k] = in_valid;
    end else begin : g_next
      assign w_x_in[k] = r_x[k-1];
      assign w_y_in[k] = r_y[k-1];
      assign w_c_in[k] = r_c[k-1];
      assign w_v_in[k] = r_v[k-1];
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a        (w_x_in[k][k*CHUNK +: CHUNK]),
      .b        (w_y_in[k][k*CHUNK +: CHUNK]),
      .ci       (w_c_in[k]),
      .s        (w_s[k]),
      .co       (w_co[k]),
      .c_msb_in (w_cm[k])
    );

    // Replace chunk k of the travelling word with its resolved sum bits.
    assign w_x_nxt[k] = (w_x_in[k] & ~L_MASK) | (WIDTH'(w_s[k]) << (k * CHUNK));
  end

  // All stage registers load together on advance; reset flushes every op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
        r_c[i] <= 1'b0;
        r_o[i] <= 1'b0;
        r_v[i] <= 1'b0;
      end
    end else if (w_adv) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        r_x[i] <= w_x_nxt[i];
        r_y[i] <= w_y_in[i];
        r_c[i] <= w_co[i];
        r_o[i] <= w_cm[i] ^ w_co[i];
        r_v[i] <= w_v_in[i];
      end
    end
  end

  assign out_valid = r_v[STAGES-1];
  assign sum       = r_x[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign ovf       = r_o[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (16/4 main instance, 8/8 single-stage instance).
module tb_pipelined_adder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  logic        d_in_valid, d_in_ready, d_cin, d_sub, d_out_valid, d_out_ready, d_cout, d_ovf;
  logic [7:0]  d_a, d_b, d_sum;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   n_sent = 0;
  int   n_recv = 0;

  pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_adder #(.WIDTH(8), .CHUNK(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .a(d_a), .b(d_b), .cin(d_cin), .sub(d_sub),
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .sum(d_sum), .cout(d_cout), .ovf(d_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Monitor: pops an expectation whenever a result transfers at the coming edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      n_recv++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got sum=%h cout=%b ovf=%b with nothing outstanding", sum, cout, ovf);
      end else begin
        e = q.pop_front();
        if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
          errors++;
          $display("FAIL result got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                   sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
        if (e.chk_lat) begin
          checks++;
          if (cyc - e.acc_cyc != LAT) begin
            errors++;
            $display("FAIL latency got=%0d expected=%0d", cyc - e.acc_cyc, LAT);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Present one op and hold it until accepted; the expectation is queued on acceptance.
  task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic xcin, input logic xsub,
                      input logic [15:0] es, input logic ec, input logic eo, input bit lat);
    a = xa; b = xb; cin = xcin; sub = xsub; in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back('{es, ec, eo, cyc, lat});
        n_sent++;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout in_ready stuck low");
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Single-stage instance: one op, result expected one cycle later.
  task automatic d_op(input logic [7:0] xa, input logic [7:0] xb, input logic xcin, input logic xsub,
                      input logic [7:0] es, input logic ec, input logic eo);
    d_a = xa; d_b = xb; d_cin = xcin; d_sub = xsub; d_in_valid = 1'b1;
    @(negedge clk);
    chk("d_in_ready", 32'(d_in_ready), 32'h1);
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    @(negedge clk);
    chk("d_out_valid", 32'(d_out_valid), 32'h1);
    chk("d_result", {22'h0, d_sum, d_cout, d_ovf}, {22'h0, es, ec, eo});
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    d_in_valid = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0; d_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_sum", 32'(sum), 32'h0);
    chk("reset_cout_ovf", {30'h0, cout, ovf}, 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h1);
    chk("reset_d_out_valid", 32'(d_out_valid), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single op with latency check.
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);
    idle(6);

    // Back-to-back stream.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    send(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b1);
    // Subtraction.
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    idle(8);

    // Stall with four ops in flight.
    out_ready = 1'b0;
    send(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
    send(16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    send(16'hF000, 16'h1000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    send(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'h0);
      chk("stall_out_valid", 32'(out_valid), 32'h1);
      chk("stall_sum", 32'(sum), 32'h0003);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(8);

    // Reset with three ops in flight.
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
    send(16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0, 1'b0);
    send(16'h0F00, 16'h0100, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    in_valid = 1'b0;
    q.delete();
    n_sent -= 3;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("no_stale_out_valid", 32'(out_valid), 32'h0);
      @(posedge clk); #1;
    end
    send(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
    send(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b1);
    in_valid = 1'b0;
    for (int n = 0; n < 20 && q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    idle(2);
    chk("drain_queue_empty", 32'(q.size()), 32'h0);
    chk("drain_count", 32'(n_recv), 32'(n_sent));

    // Degenerate single-stage configuration.
    d_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    d_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    d_op(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    d_op(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
    @(negedge clk);
    chk("d_bubble_out_valid", 32'(d_out_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
